// File: rtl/dma_pkg.sv
// Shared types and bus field widths for the burst DMA engine.
package dma_pkg;
    localparam int DATA_W  = 32;
    localparam int BE_W    = 4;
    localparam int BSIZE_W = 8;
    localparam int LEN_W   = 9;

    typedef enum logic [2:0] {
        IDLE, FILL, REQ, HSHAKE, WDATA, RDATA, END, DONE
    } dma_state_t;

    typedef enum logic {
        MODE_WRITE = 1'b0,
        MODE_READ  = 1'b1
    } dma_mode_t;
endpackage

// File: rtl/dma_burst_fifo.sv
// Burst staging FIFO: head visible combinationally, push/pop in the same cycle allowed.
// Push is dropped when full, pop when empty; flush empties it in one cycle.
module dma_burst_fifo
    import dma_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_dat,
    output logic [DATA_W-1:0] o_dat,
    output logic              o_full,
    output logic              o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wp;
    logic [AW-1:0]     r_rp;
    logic [AW:0]       r_cnt;
    logic              w_push;
    logic              w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_dat   = r_mem[r_rp];

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= next_ptr(r_wp);
            if (w_pop)  r_rp <= next_ptr(r_rp);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) r_mem[r_wp] <= i_dat;
    end
endmodule

// File: rtl/burst_dma.sv
// Multi-word DMA between local buffer and shared bus, split into bursts of at most MAX_BURST.
// Write bursts stage len+1 cycles in the FIFO before requesting; busyIN holds the FIFO head.
module burst_dma
    import dma_pkg::*;
#(
    parameter int BUF_AW    = 9,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_write,
    input  logic               start_read,
    input  logic [31:0]        bus_address,
    input  logic [BUF_AW-1:0]  buf_start,
    input  logic [CNT_W-1:0]   word_count,
    input  logic [BE_W-1:0]    byte_enable,
    output logic               idle,
    output logic               done,
    output logic               error,
    output logic [BUF_AW-1:0]  bufferAddress,
    output logic [DATA_W-1:0]  dataIn,
    output logic               writeEnable,
    input  logic [DATA_W-1:0]  dataOut,
    input  logic [DATA_W-1:0]  address_dataIN,
    input  logic               end_transactionIN,
    input  logic               data_validIN,
    input  logic               busyIN,
    input  logic               errorIN,
    output logic [DATA_W-1:0]  address_dataOUT,
    output logic [BE_W-1:0]    byte_enableOUT,
    output logic [BSIZE_W-1:0] burst_sizeOUT,
    output logic               read_n_writeOUT,
    output logic               begin_transactionOUT,
    output logic               end_transactionOUT,
    output logic               data_validOUT,
    output logic               busyOUT,
    output logic               request,
    input  logic               granted
);
    dma_state_t        r_state;
    dma_mode_t         r_mode;
    logic [31:0]       r_addr;
    logic [BUF_AW-1:0] r_ptr;
    logic [CNT_W-1:0]  r_rem;
    logic [BE_W-1:0]   r_be;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_pend;
    logic              r_err;

    logic [LEN_W-1:0]  w_len;
    logic              w_issue;
    logic              w_err_hit;
    logic              w_pop;
    logic [DATA_W-1:0] w_fifo_dat;
    logic              w_fifo_full;
    logic              w_fifo_empty;

    always_comb begin
        w_len = LEN_W'(r_rem);
        if (32'(r_rem) > MAX_BURST) w_len = LEN_W'(MAX_BURST);
    end

    assign w_issue   = (r_state == FILL) && (r_cnt < w_len);
    assign w_err_hit = errorIN && ((r_state == REQ) || (r_state == HSHAKE) ||
                                   (r_state == WDATA) || (r_state == RDATA));
    assign w_pop     = (r_state == WDATA) && !busyIN && !errorIN && !w_fifo_empty;

    dma_burst_fifo #(.DEPTH(MAX_BURST)) u_fifo (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_push  (r_pend && !w_fifo_full),
        .i_pop   (w_pop),
        .i_flush (w_err_hit),
        .i_dat   (dataOut),
        .o_dat   (w_fifo_dat),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_mode  <= MODE_WRITE;
            r_addr  <= '0;
            r_ptr   <= '0;
            r_rem   <= '0;
            r_be    <= '0;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start_write || start_read) begin
                    r_mode <= start_write ? MODE_WRITE : MODE_READ;
                    r_addr <= bus_address;
                    r_ptr  <= buf_start;
                    r_rem  <= word_count;
                    r_be   <= byte_enable;
                    r_cnt  <= '0;
                    r_pend <= 1'b0;
                    r_err  <= 1'b0;
                    if (word_count == '0) r_state <= DONE;
                    else                  r_state <= start_write ? FILL : REQ;
                end
                // Buffer data lags its address by one cycle, so FILL ends on the last push.
                FILL: begin
                    r_pend <= w_issue;
                    if (w_issue) begin
                        r_ptr <= r_ptr + 1'b1;
                        r_cnt <= r_cnt + 1'b1;
                    end else if (r_pend) begin
                        r_cnt   <= '0;
                        r_state <= REQ;
                    end
                end
                REQ: if (errorIN) begin
                    r_err   <= 1'b1;
                    r_state <= DONE;
                end else if (granted) begin
                    r_state <= HSHAKE;
                end
                HSHAKE: if (errorIN) begin
                    r_err   <= 1'b1;
                    r_state <= DONE;
                end else begin
                    r_cnt   <= '0;
                    r_state <= (r_mode == MODE_WRITE) ? WDATA : RDATA;
                end
                WDATA: if (errorIN) begin
                    r_err   <= 1'b1;
                    r_state <= DONE;
                end else if (!busyIN) begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == w_len - LEN_W'(1)) r_state <= END;
                end
                RDATA: if (errorIN) begin
                    r_err   <= 1'b1;
                    r_state <= DONE;
                end else begin
                    if (data_validIN)      r_ptr   <= r_ptr + 1'b1;
                    if (end_transactionIN) r_state <= END;
                end
                END: begin
                    r_addr <= r_addr + 32'({w_len, 2'b00});
                    r_rem  <= r_rem - CNT_W'(w_len);
                    r_cnt  <= '0;
                    r_pend <= 1'b0;
                    if (r_rem != CNT_W'(w_len))
                        r_state <= (r_mode == MODE_WRITE) ? FILL : REQ;
                    else
                        r_state <= DONE;
                end
                DONE: begin
                    r_err   <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign idle                 = (r_state == IDLE);
    assign done                 = (r_state == DONE);
    assign error                = done && r_err;
    assign request              = (r_state == REQ) && !granted;
    assign bufferAddress        = (w_issue || (r_state == RDATA)) ? r_ptr : '0;
    assign writeEnable          = (r_state == RDATA) && data_validIN && !errorIN;
    assign dataIn               = writeEnable ? address_dataIN : '0;
    assign begin_transactionOUT = (r_state == HSHAKE);
    assign address_dataOUT      = (r_state == HSHAKE) ? r_addr :
                                  (r_state == WDATA)  ? w_fifo_dat : '0;
    assign byte_enableOUT       = (r_state == HSHAKE) ? r_be : '0;
    assign burst_sizeOUT        = (r_state == HSHAKE) ? BSIZE_W'(w_len - LEN_W'(1)) : '0;
    assign read_n_writeOUT      = (r_state == HSHAKE) && (r_mode == MODE_READ);
    assign end_transactionOUT   = ((r_state == END) && (r_mode == MODE_WRITE)) || w_err_hit;
    assign data_validOUT        = (r_state == WDATA);
    assign busyOUT              = 1'b0;
endmodule

// File: tb/tb_burst_dma.sv
// Directed bench for burst_dma: transaction-level model of bursts, bus words and buffer writes.
module tb_burst_dma;
    localparam int MB = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start_write = 0, start_read = 0;
    logic [31:0] bus_address = '0;
    logic [8:0]  buf_start = '0;
    logic [9:0]  word_count = '0;
    logic [3:0]  byte_enable = '0;
    logic        idle, done, error;
    logic [8:0]  bufferAddress;
    logic [31:0] dataIn;
    logic        writeEnable;
    logic [31:0] dataOut = '0;
    logic [31:0] address_dataIN = '0;
    logic        end_transactionIN = 0, data_validIN = 0, busyIN = 0, errorIN = 0;
    logic [31:0] address_dataOUT;
    logic [3:0]  byte_enableOUT;
    logic [7:0]  burst_sizeOUT;
    logic        read_n_writeOUT, begin_transactionOUT, end_transactionOUT;
    logic        data_validOUT, busyOUT, request;
    logic        granted = 0;

    burst_dma #(.BUF_AW(9), .MAX_BURST(MB), .CNT_W(10)) u_dut (
        .clock(clock), .reset(reset), .start_write(start_write), .start_read(start_read),
        .bus_address(bus_address), .buf_start(buf_start), .word_count(word_count),
        .byte_enable(byte_enable), .idle(idle), .done(done), .error(error),
        .bufferAddress(bufferAddress), .dataIn(dataIn), .writeEnable(writeEnable),
        .dataOut(dataOut), .address_dataIN(address_dataIN),
        .end_transactionIN(end_transactionIN), .data_validIN(data_validIN),
        .busyIN(busyIN), .errorIN(errorIN), .address_dataOUT(address_dataOUT),
        .byte_enableOUT(byte_enableOUT), .burst_sizeOUT(burst_sizeOUT),
        .read_n_writeOUT(read_n_writeOUT), .begin_transactionOUT(begin_transactionOUT),
        .end_transactionOUT(end_transactionOUT), .data_validOUT(data_validOUT),
        .busyOUT(busyOUT), .request(request), .granted(granted)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [512];
    always @(posedge clock) dataOut <= mem[bufferAddress];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // Model expectations: {addr, size, rnw, be}, bus write words, {buf addr, data}.
    logic [44:0] exp_burst [$];
    logic [31:0] exp_wdata [$];
    logic [40:0] exp_bwr   [$];
    logic [31:0] obs_ba [$];
    logic [7:0]  obs_bs [$];
    logic [31:0] obs_wd [$];
    logic [8:0]  obs_bwa [$];
    int n_req = 0, n_endt = 0, n_done = 0, n_err = 0;
    logic prev_req = 0;

    task automatic model_xfer(input bit rd, input logic [31:0] a0, input int bp,
                              input int n, input logic [3:0] be);
        logic [31:0] a;
        int rem, idx, len;
        a = a0; rem = n; idx = 0;
        while (rem > 0) begin
            len = (rem > MB) ? MB : rem;
            exp_burst.push_back({a, 8'(len - 1), rd, be});
            for (int k = 0; k < len; k++) begin
                if (rd) exp_bwr.push_back({9'((bp + idx) % 512), 32'hD000_0000 + 32'(idx)});
                else    exp_wdata.push_back(mem[(bp + idx) % 512]);
                idx++;
            end
            a = a + 32'(4 * len);
            rem = rem - len;
        end
    endtask

    logic [93:0] all_outs;
    assign all_outs = {done, error, bufferAddress, dataIn, writeEnable, address_dataOUT,
                       byte_enableOUT, burst_sizeOUT, read_n_writeOUT, begin_transactionOUT,
                       end_transactionOUT, data_validOUT, busyOUT, request};

    always @(negedge clock) begin
        if (!reset) begin
            chk("busyOUT", 64'(busyOUT), 0);
            if (request && !prev_req) n_req++;
            prev_req = request;
            if (end_transactionOUT) n_endt++;
            if (done) n_done++;
            if (error) n_err++;
            if (begin_transactionOUT) begin
                obs_ba.push_back(address_dataOUT);
                obs_bs.push_back(burst_sizeOUT);
                chk("burst_hdr", {address_dataOUT, burst_sizeOUT, read_n_writeOUT, byte_enableOUT},
                    (exp_burst.size() > 0) ? exp_burst.pop_front() : 45'h0);
            end
            if (data_validOUT) begin
                chk("wdata", address_dataOUT, (exp_wdata.size() > 0) ? exp_wdata[0] : 32'hDEAD_BEEF);
                if (!busyIN) begin
                    obs_wd.push_back(address_dataOUT);
                    if (exp_wdata.size() > 0) void'(exp_wdata.pop_front());
                end
            end
            if (writeEnable) begin
                obs_bwa.push_back(bufferAddress);
                chk("buf_write", {bufferAddress, dataIn},
                    (exp_bwr.size() > 0) ? exp_bwr.pop_front() : {41{1'b1}});
            end
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic clear_logs();
        obs_ba.delete(); obs_bs.delete(); obs_wd.delete(); obs_bwa.delete();
        exp_burst.delete(); exp_wdata.delete(); exp_bwr.delete();
        n_req = 0; n_endt = 0; n_done = 0; n_err = 0;
    endtask

    task automatic start(input bit w, input bit r, input logic [31:0] a, input int bp,
                         input int n, input logic [3:0] be);
        bus_address = a; buf_start = 9'(bp); word_count = 10'(n); byte_enable = be;
        start_write = w; start_read = r;
        tick();
        start_write = 0; start_read = 0;
    endtask

    // Bus slave + arbiter: one iteration per cycle, outputs read before inputs are changed.
    task automatic serve(input int gdly, input int busy_at, input int busy_n, input int err_word,
                         input int rst_at, output bit err_seen, output int frs);
        int rc = 0, wc = 0, bleft, rd_left = 0, rd_idx = 0;
        bit fin = 0;
        logic lv_req, lv_dv, lv_beg, lv_rnw;
        logic [7:0] lv_bs;
        bleft = busy_n; err_seen = 0; frs = -1;
        for (int j = 0; j < 3000; j++) begin
            if (j == rst_at) begin
                reset = 1; #1;
                chk("rst_outs_nonzero", 64'(|all_outs), 0);
                chk("rst_idle", 64'(idle), 1);
                granted = 0; data_validIN = 0; end_transactionIN = 0; address_dataIN = 0;
                busyIN = 0; errorIN = 0;
                reset = 0;
                fin = 1;
                break;
            end
            if (done) begin
                err_seen = error; fin = 1;
                break;
            end
            lv_req = request; lv_dv = data_validOUT; lv_beg = begin_transactionOUT;
            lv_rnw = read_n_writeOUT; lv_bs = burst_sizeOUT;
            if (lv_req && frs < 0) frs = j;
            if (granted) granted = 0;
            else if (lv_req) begin
                if (rc == gdly) begin granted = 1; rc = 0; end
                else rc++;
            end
            data_validIN = 0; end_transactionIN = 0; address_dataIN = 0;
            if (rd_left > 0) begin
                data_validIN = 1;
                address_dataIN = 32'hD000_0000 + 32'(rd_idx);
                end_transactionIN = (rd_left == 1);
                rd_idx++; rd_left--;
            end
            if (lv_beg && lv_rnw) rd_left = int'(lv_bs) + 1;
            busyIN = 0; errorIN = 0;
            if (lv_dv) begin
                if (wc == busy_at && bleft > 0) begin busyIN = 1; bleft--; end
                else begin
                    if (wc == err_word) errorIN = 1;
                    wc++;
                end
            end
            if (errorIN) begin
                #1;
                chk("end_on_error", 64'(end_transactionOUT), 1);
            end
            tick();
        end
        chk("no_timeout", 64'(fin), 1);
        granted = 0; busyIN = 0; errorIN = 0; data_validIN = 0; end_transactionIN = 0;
        address_dataIN = 0;
    endtask

    bit es;
    int fr;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'hA0 + 32'(i);
        #2 reset = 1;
        tick(); tick();
        chk("reset_outs_nonzero", 64'(|all_outs), 0);
        chk("reset_idle", 64'(idle), 1);
        reset = 0;
        tick();
        chk("idle_after_reset", 64'(idle), 1);

        // Single write burst, grant after two request cycles.
        clear_logs();
        model_xfer(0, 32'h4000_0100, 0, 4, 4'hF);
        start(1, 0, 32'h4000_0100, 0, 4, 4'hF);
        serve(2, -1, 0, -1, -1, es, fr);
        tick();
        chk("w1_error", 64'(es), 0);
        chk("w1_first_req_step", 64'(fr), 5);
        chk("w1_req_count", 64'(n_req), 1);
        chk("w1_endt_count", 64'(n_endt), 1);
        chk("w1_done_count", 64'(n_done), 1);
        chk("w1_addr", 64'(obs_ba[0]), 64'h4000_0100);
        chk("w1_size", 64'(obs_bs[0]), 3);
        chk("w1_word0", 64'(obs_wd[0]), 64'hA0);
        chk("w1_word3", 64'(obs_wd[3]), 64'hA3);
        chk("w1_words_left", 64'(exp_wdata.size()), 0);
        chk("w1_idle", 64'(idle), 1);

        // Read of 20 words splits into 16 + 4.
        clear_logs();
        model_xfer(1, 32'h8000_0000, 0, 20, 4'h3);
        start(0, 1, 32'h8000_0000, 0, 20, 4'h3);
        serve(1, -1, 0, -1, -1, es, fr);
        tick();
        chk("r2_first_req_step", 64'(fr), 0);
        chk("r2_req_count", 64'(n_req), 2);
        chk("r2_endt_count", 64'(n_endt), 0);
        chk("r2_addr1", 64'(obs_ba[1]), 64'h8000_0040);
        chk("r2_size0", 64'(obs_bs[0]), 15);
        chk("r2_size1", 64'(obs_bs[1]), 3);
        chk("r2_last_bufaddr", 64'(obs_bwa[19]), 19);
        chk("r2_writes_left", 64'(exp_bwr.size()), 0);

        // Backpressure: busy for three cycles on the third word.
        clear_logs();
        model_xfer(0, 32'h0000_1000, 10, 6, 4'hF);
        start(1, 0, 32'h0000_1000, 10, 6, 4'hF);
        serve(0, 2, 3, -1, -1, es, fr);
        tick();
        chk("bp_word_count", 64'(obs_wd.size()), 6);
        chk("bp_word2", 64'(obs_wd[2]), 64'hAC);
        chk("bp_words_left", 64'(exp_wdata.size()), 0);

        // Error on the second word of a write burst.
        clear_logs();
        model_xfer(0, 32'h0000_2000, 0, 4, 4'hF);
        start(1, 0, 32'h0000_2000, 0, 4, 4'hF);
        serve(0, -1, 0, 1, -1, es, fr);
        chk("err_flag_with_done", 64'(es), 1);
        tick();
        chk("err_idle", 64'(idle), 1);
        chk("err_fifo_empty", 64'(u_dut.u_fifo.o_empty), 1);
        chk("err_pulses", 64'(n_err), 1);
        chk("err_endt_count", 64'(n_endt), 1);

        // Simultaneous starts pick write; single-word burst after the aborted one.
        clear_logs();
        model_xfer(0, 32'h0000_3000, 100, 1, 4'h5);
        start(1, 1, 32'h0000_3000, 100, 1, 4'h5);
        serve(0, -1, 0, -1, -1, es, fr);
        tick();
        chk("both_size", 64'(obs_bs[0]), 0);
        chk("both_word", 64'(obs_wd[0]), 64'h104);
        chk("both_words_left", 64'(exp_wdata.size()), 0);

        // Zero word count completes without touching the bus.
        clear_logs();
        start(1, 0, 32'h0000_4000, 0, 0, 4'hF);
        serve(0, -1, 0, -1, -1, es, fr);
        tick();
        chk("zero_first_req", 64'(fr), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("zero_req_count", 64'(n_req), 0);
        chk("zero_bursts", 64'(obs_ba.size()), 0);
        chk("zero_done_count", 64'(n_done), 1);

        // Buffer pointer wraps from 511 to 0.
        clear_logs();
        model_xfer(1, 32'h0000_5000, 511, 2, 4'hF);
        start(0, 1, 32'h0000_5000, 511, 2, 4'hF);
        serve(0, -1, 0, -1, -1, es, fr);
        tick();
        chk("wrap_addr0", 64'(obs_bwa[0]), 511);
        chk("wrap_addr1", 64'(obs_bwa[1]), 0);
        chk("wrap_writes_left", 64'(exp_bwr.size()), 0);

        // Reset while receiving read data.
        clear_logs();
        model_xfer(1, 32'h0000_6000, 20, 8, 4'hF);
        start(0, 1, 32'h0000_6000, 20, 8, 4'hF);
        serve(0, -1, 0, -1, 4, es, fr);
        chk("rst_writes_before", 64'(obs_bwa.size()), 2);
        tick();
        chk("rst_idle_after", 64'(idle), 1);
        chk("rst_no_request", 64'(request), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
